// File: rtl/frame_tx_ram.sv
// frame_tx_ram: payload RAM plus frame transmitter for a 16-bit valid/ready
// word stream. A host fills the RAM while the block is idle, then issues start
// with a length. The block streams mem[0..len-1] and appends TERM_WORD.
//
// Optional feature macro: FRAME_TX_CKSUM_EN
//   When defined, the XOR of all payload words is sent between the last
//   payload word and the terminator.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no frame in flight; RAM writable; start accepted here
// PAYLOAD | presenting mem[rd_ptr]; advances one word per handshake
// CKSUM   | presenting XOR of the payload (FRAME_TX_CKSUM_EN only)
// TERM    | presenting TERM_WORD with tx_last; handshake ends the frame

module frame_tx_ram #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    MEM_SIZE   = 256,
  parameter logic [DATA_WIDTH-1:0] TERM_WORD  = 16'hAABB,
  localparam int                   AW         = $clog2(MEM_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  start,
  input  logic [AW:0]           len,
  output logic                  busy,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_last,
  output logic                  done,
  output logic                  err_term
);

`ifdef FRAME_TX_CKSUM_EN
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_CKSUM   = 2'd2,
    S_TERM    = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_TERM    = 2'd3
  } state_t;
`endif

  localparam logic [AW:0] MEM_SIZE_L = (AW+1)'(MEM_SIZE);

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];
  logic [AW:0]           len_q;
  logic [AW:0]           rd_ptr;
  logic [AW:0]           nxt_ptr;
  logic [AW:0]           len_clamp;
  logic                  hs;
  logic                  last_word;
  logic                  start_ok;
`ifdef FRAME_TX_CKSUM_EN
  logic [DATA_WIDTH-1:0] cksum;
`endif

  assign hs        = tx_valid & tx_ready;
  assign start_ok  = (state == S_IDLE) & start;
  assign len_clamp = (len > MEM_SIZE_L) ? MEM_SIZE_L : len;
  assign nxt_ptr   = rd_ptr + 1'b1;
  // rd_ptr is one bit wider than the RAM address so len=MEM_SIZE terminates
  // cleanly instead of aliasing back to address 0.
  assign last_word = (nxt_ptr == len_q);

  // Payload RAM write port; frozen while a frame is in flight.
  always_ff @(posedge clk) begin
    if (we && (state == S_IDLE)) mem[wr_addr] <= din;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (len_clamp == '0) begin
`ifdef FRAME_TX_CKSUM_EN
            state_nxt = S_CKSUM;
`else
            state_nxt = S_TERM;
`endif
          end else begin
            state_nxt = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (hs && last_word) begin
`ifdef FRAME_TX_CKSUM_EN
          state_nxt = S_CKSUM;
`else
          state_nxt = S_TERM;
`endif
        end
      end
`ifdef FRAME_TX_CKSUM_EN
      S_CKSUM: if (hs) state_nxt = S_TERM;
`endif
      S_TERM:  if (hs) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stream datapath: the next word is loaded on the same edge as the handshake
  // so a continuously ready sink sees one word per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      tx_last  <= 1'b0;
      done     <= 1'b0;
      err_term <= 1'b0;
      rd_ptr   <= '0;
      len_q    <= '0;
`ifdef FRAME_TX_CKSUM_EN
      cksum    <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            len_q    <= len_clamp;
            rd_ptr   <= '0;
            busy     <= 1'b1;
            tx_valid <= 1'b1;
            err_term <= 1'b0;
`ifdef FRAME_TX_CKSUM_EN
            cksum    <= '0;
`endif
            if (len_clamp == '0) begin
`ifdef FRAME_TX_CKSUM_EN
              tx_data <= '0;
              tx_last <= 1'b0;
`else
              tx_data <= TERM_WORD;
              tx_last <= 1'b1;
`endif
            end else begin
              tx_data <= mem[0];
              tx_last <= 1'b0;
            end
          end
        end
        S_PAYLOAD: begin
          if (hs) begin
            rd_ptr <= nxt_ptr;
            if (tx_data == TERM_WORD) err_term <= 1'b1;
`ifdef FRAME_TX_CKSUM_EN
            cksum <= cksum ^ tx_data;
`endif
            if (last_word) begin
`ifdef FRAME_TX_CKSUM_EN
              tx_data <= cksum ^ tx_data;
              tx_last <= 1'b0;
`else
              tx_data <= TERM_WORD;
              tx_last <= 1'b1;
`endif
            end else begin
              tx_data <= mem[nxt_ptr[AW-1:0]];
            end
          end
        end
`ifdef FRAME_TX_CKSUM_EN
        S_CKSUM: begin
          if (hs) begin
            if (tx_data == TERM_WORD) err_term <= 1'b1;
            tx_data <= TERM_WORD;
            tx_last <= 1'b1;
          end
        end
`endif
        S_TERM: begin
          if (hs) begin
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_tx_ram.sv
// Scoreboard bench for frame_tx_ram. Expected frames are derived from a
// shadow copy of the payload RAM; a negedge monitor compares every handshake.
module tb_frame_tx_ram;
  localparam int          MS   = 256;
  localparam logic [15:0] TERM = 16'hAABB;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [7:0]  wr_addr;
  logic [15:0] din;
  logic        start;
  logic [8:0]  len;
  logic        busy;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] tx_data;
  logic        tx_last;
  logic        done;
  logic        err_term;

  frame_tx_ram dut (
    .clk(clk), .rst_n(rst_n), .we(we), .wr_addr(wr_addr), .din(din),
    .start(start), .len(len), .busy(busy), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_data(tx_data), .tx_last(tx_last),
    .done(done), .err_term(err_term)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [16:0] exp_q [$];
  logic [15:0] model_mem [MS];
  int          ready_mode = 0;
  int          done_cnt = 0;
  int          pops = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Sink backpressure: 0 always ready, 1 pattern 1,0,0, 2 random, 3 held by test.
  initial begin
    int rcnt = 0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: tx_ready = 1'b1;
        1: begin tx_ready = (rcnt % 3 == 0); rcnt++; end
        2: tx_ready = 1'($urandom_range(0, 1));
        default: ;
      endcase
    end
  end

  // Monitor: handshake compare against scoreboard, hold-while-stalled check.
  initial begin
    logic        stalled = 1'b0;
    logic [16:0] held = '0;
    logic [16:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (done) done_cnt++;
        if (stalled && !tx_valid) begin
          total++; bad++;
          $display("FAIL valid_drop got=0 exp=1");
        end
        if (tx_valid) begin
          if (stalled) begin
            total++;
            if ({tx_last, tx_data} !== held) begin
              bad++;
              $display("FAIL hold got=%0h exp=%0h", {tx_last, tx_data}, held);
            end
          end
          if (tx_ready) begin
            stalled = 1'b0;
            pops++;
            total++;
            if (exp_q.size() == 0) begin
              bad++;
              $display("FAIL unexpected_word got=%0h exp=none", {tx_last, tx_data});
            end else begin
              e = exp_q.pop_front();
              if ({tx_last, tx_data} !== e) begin
                bad++;
                $display("FAIL word got=%0h exp=%0h", {tx_last, tx_data}, e);
              end
            end
          end else begin
            stalled = 1'b1;
            held    = {tx_last, tx_data};
          end
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  task automatic write_word(input int a, input logic [15:0] d);
    wr_addr = 8'(a); din = d; we = 1'b1;
    @(posedge clk); #1;
    we = 1'b0;
    model_mem[a] = d;
  endtask

  // Reference frame: first min(len,256) RAM words, optional XOR, terminator.
  task automatic push_frame(input int l, output logic err);
    int          n;
    logic [15:0] ck;
    n   = (l > MS) ? MS : l;
    ck  = '0;
    err = 1'b0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({1'b0, model_mem[i]});
      ck ^= model_mem[i];
      if (model_mem[i] == TERM) err = 1'b1;
    end
`ifdef FRAME_TX_CKSUM_EN
    exp_q.push_back({1'b0, ck});
    if (ck == TERM) err = 1'b1;
`endif
    exp_q.push_back({1'b1, TERM});
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 5000) begin
      total++; bad++;
      $display("FAIL timeout got=%0d exp=0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk); #1;
  endtask

  task automatic fire_start(input int l);
    start = 1'b1; len = 9'(l);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_frame(input int l, input int mode);
    logic e;
    int   d0;
    ready_mode = mode;
    push_frame(l, e);
    d0 = done_cnt;
    fire_start(l);
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("valid_after_start", 32'(tx_valid), 32'd1);
    chk("err_cleared", 32'(err_term), 32'd0);
    wait_idle();
    chk("done_once", 32'(done_cnt - d0), 32'd1);
    chk("busy_low", 32'(busy), 32'd0);
    chk("valid_low", 32'(tx_valid), 32'd0);
    chk("err_term", 32'(err_term), 32'(e));
  endtask

  task automatic b2b(input int l1, input int l2);
    logic e;
    int   d0;
    int   n;
    ready_mode = 0;
    d0 = done_cnt;
    push_frame(l1, e);
    fire_start(l1);
    n = 0;
    while (!done && n < 2000) begin @(posedge clk); #1; n++; end
    chk("b2b_done_seen", 32'(done), 32'd1);
    push_frame(l2, e);
    fire_start(l2);
    chk("b2b_busy", 32'(busy), 32'd1);
    wait_idle();
    chk("b2b_done_cnt", 32'(done_cnt - d0), 32'd2);
    chk("b2b_err", 32'(err_term), 32'(e));
  endtask

  task automatic reset_mid_frame();
    logic e;
    int   base;
    int   n;
    ready_mode = 0;
    push_frame(3, e);
    base = pops;
    fire_start(3);
    n = 0;
    while (pops < base + 1 && n < 100) begin @(posedge clk); #2; n++; end
    chk("mid_first_word", 32'(pops - base), 32'd1);
    we = 1'b1; wr_addr = 8'd2; din = 16'hFFFF; start = 1'b1; len = 9'd5;
    @(posedge clk); #1;
    we = 1'b0; start = 1'b0;
    n = 0;
    while (pops < base + 3 && n < 100) begin @(posedge clk); #2; n++; end
    ready_mode = 3;
    tx_ready = 1'b0;
    chk("mid_three_words", 32'(pops - base), 32'd3);
`ifdef FRAME_TX_CKSUM_EN
    chk("mid_last_before_rst", 32'(tx_last), 32'd0);
`else
    chk("mid_last_before_rst", 32'(tx_last), 32'd1);
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_last", 32'(tx_last), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    ready_mode = 0;
    tx_ready = 1'b1;
  endtask

  initial begin
    int l;
    rst_n = 1'b0; we = 1'b0; wr_addr = '0; din = '0;
    start = 1'b0; len = '0; tx_ready = 1'b1;
    for (int i = 0; i < MS; i++) model_mem[i] = '0;
    #12;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_valid", 32'(tx_valid), 32'd0);
    chk("reset_last", 32'(tx_last), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_err", 32'(err_term), 32'd0);
    chk("reset_data", 32'(tx_data), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // RAM contents are unknown after power-up; give every word a value.
    for (int i = 0; i < MS; i++) write_word(i, 16'(i * 7 + 1));

    write_word(0, 16'h1111);
    write_word(1, 16'h2222);
    write_word(2, 16'h3333);
    run_frame(3, 0);
    run_frame(3, 1);
    run_frame(0, 0);

    write_word(1, TERM);
    run_frame(3, 0);
    write_word(1, 16'h2222);
    run_frame(3, 2);

    reset_mid_frame();
    run_frame(1, 0);
    run_frame(3, 0);

    b2b(2, 4);

    for (int i = 0; i < MS; i++) write_word(i, 16'(i));
    run_frame(256, 0);
    run_frame(300, 1);

    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 12; j++) begin
        if ($urandom_range(0, 9) == 0) write_word($urandom_range(0, 40), TERM);
        else write_word($urandom_range(0, 40), 16'($urandom));
      end
      l = (k == 5) ? $urandom_range(257, 511) : $urandom_range(0, 40);
      run_frame(l, $urandom_range(0, 2));
    end

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "global timeout");
  end
endmodule
